fifo_dma_drain: RTL and testbench

//  Read-side companion of the floppy controller data FIFO: pops bytes from a show-ahead

---
 rtl/floppy_dma_pkg.sv | 11 +
 rtl/fifo_dma_drain.sv | 114 +++++++++++
 tb/tb_fifo_dma_drain.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/floppy_dma_pkg.sv
// Shared types for the floppy controller FIFO <-> DMA bridges.
// The drain (FIFO->DMA) uses this now; the write-direction filler will use it later.
package floppy_dma_pkg;

    typedef enum logic [1:0] {
        DRN_IDLE,
        DRN_REQ,
        DRN_DONE
    } drain_state_t;

endpackage : floppy_dma_pkg

// File: rtl/fifo_dma_drain.sv
// Drains a show-ahead FIFO into an 8237-style DMA channel. One byte is held in dma_data
// behind DREQ, with back-to-back refills on DACK, a stop on terminal count and a sticky stray-DACK flag.
module fifo_dma_drain
    import floppy_dma_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int WIDTHU    = 4,
    parameter int THRESHOLD = 1,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclr,
    input  logic               enable,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    input  logic [WIDTHU-1:0]  fifo_usedw,
    input  logic [WIDTH-1:0]   fifo_q,
    output logic               fifo_rdreq,
    output logic               dma_req,
    input  logic               dma_ack,
    input  logic               dma_tc,
    output logic [WIDTH-1:0]   dma_data,
    output logic [COUNT_W-1:0] xfer_count,
    output logic               done,
    output logic               ack_error
);

    localparam logic [WIDTHU:0] LEVEL_FULL = (WIDTHU + 1)'(2 ** WIDTHU);
    localparam logic [WIDTHU:0] THRESH     = (WIDTHU + 1)'(THRESHOLD);

    drain_state_t       state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               err_q, err_d;
    logic               pop;
    logic               can_pop;
    logic [WIDTHU:0]    level;

    // usedw wraps to zero when the FIFO is full, so the full flag supplies the top value.
    assign level   = fifo_full ? LEVEL_FULL : {1'b0, fifo_usedw};
    assign can_pop = enable && !fifo_empty;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        err_d   = err_q;
        pop     = 1'b0;

        if (sclr) begin
            state_d = DRN_IDLE;
            data_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                DRN_IDLE: begin
                    if (dma_ack) err_d = 1'b1;
                    if (can_pop && level >= THRESH) begin
                        pop     = 1'b1;
                        data_d  = fifo_q;
                        state_d = DRN_REQ;
                    end
                end
                DRN_REQ: begin
                    if (dma_ack) begin
                        if (count_q != '1) count_d = count_q + 1'b1;
                        // Terminal count takes priority over refilling from the FIFO.
                        if (dma_tc) begin
                            state_d = DRN_DONE;
                        end else if (can_pop) begin
                            pop    = 1'b1;
                            data_d = fifo_q;
                        end else begin
                            state_d = DRN_IDLE;
                        end
                    end
                end
                DRN_DONE: begin
                    if (dma_ack) err_d = 1'b1;
                end
                default: state_d = DRN_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DRN_IDLE;
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // The state is IDLE during reset, so the pop strobe must also be masked by rst.
    assign fifo_rdreq = pop && !rst;
    assign dma_req    = (state_q == DRN_REQ);
    assign done       = (state_q == DRN_DONE);
    assign dma_data   = data_q;
    assign xfer_count = count_q;
    assign ack_error  = err_q;

endmodule : fifo_dma_drain

// File: tb/tb_fifo_dma_drain.sv
// Bench for fifo_dma_drain: three lanes (THRESHOLD 1, 4, 16), each fed by a behavioural
// show-ahead FIFO. A scoreboard queue holds pushed bytes until the DMA side acks them.
module tb_fifo_dma_drain;

    localparam int NL = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NL-1:0]    sclr, enable, dma_ack, dma_tc;
    logic [NL-1:0]    fifo_empty, fifo_full, fifo_rdreq, dma_req, done, ack_error;
    logic [3:0]       fifo_usedw [NL];
    logic [7:0]       fifo_q     [NL];
    logic [7:0]       dma_data   [NL];
    logic [15:0]      xfer_count [NL];

    // behavioural FIFO state
    logic [NL-1:0]    push_v, fclr, underflow;
    logic [7:0]       push_d [NL];
    logic [7:0]       fmem   [NL][16];
    logic [4:0]       fcnt   [NL];
    logic [3:0]       wp     [NL];
    logic [3:0]       rp     [NL];

    logic [7:0]       sb [$];
    int               n_checks = 0;
    int               n_err    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        fifo_dma_drain #(
            .WIDTH(8), .WIDTHU(4),
            .THRESHOLD((g == 0) ? 1 : (g == 1) ? 4 : 16),
            .COUNT_W(16)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .sclr       (sclr[g]),
            .enable     (enable[g]),
            .fifo_empty (fifo_empty[g]),
            .fifo_full  (fifo_full[g]),
            .fifo_usedw (fifo_usedw[g]),
            .fifo_q     (fifo_q[g]),
            .fifo_rdreq (fifo_rdreq[g]),
            .dma_req    (dma_req[g]),
            .dma_ack    (dma_ack[g]),
            .dma_tc     (dma_tc[g]),
            .dma_data   (dma_data[g]),
            .xfer_count (xfer_count[g]),
            .done       (done[g]),
            .ack_error  (ack_error[g])
        );
    end

    always_comb begin
        for (int l = 0; l < NL; l++) begin
            fifo_empty[l] = (fcnt[l] == 5'd0);
            fifo_full[l]  = (fcnt[l] == 5'd16);
            fifo_usedw[l] = fcnt[l][3:0];
            fifo_q[l]     = fmem[l][rp[l]];
        end
    end

    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (fclr[l]) begin
                fcnt[l] <= '0;
                wp[l]   <= '0;
                rp[l]   <= '0;
            end else begin
                if (push_v[l] && fcnt[l] != 5'd16) begin
                    fmem[l][wp[l]] <= push_d[l];
                    wp[l]          <= wp[l] + 4'd1;
                end
                if (fifo_rdreq[l] && fcnt[l] != 5'd0) rp[l] <= rp[l] + 4'd1;
                fcnt[l] <= fcnt[l]
                         + ((push_v[l] && fcnt[l] != 5'd16) ? 5'd1 : 5'd0)
                         - ((fifo_rdreq[l] && fcnt[l] != 5'd0) ? 5'd1 : 5'd0);
            end
            if (fifo_rdreq[l] && fcnt[l] == 5'd0) underflow[l] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int l, input logic [7:0] d);
        push_v[l] = 1'b1;
        push_d[l] = d;
        sb.push_back(d);
        tick();
        push_v[l] = 1'b0;
    endtask

    // Compare the offered byte against the scoreboard, then ack it for one cycle.
    task automatic do_ack(input int l, input logic tc_v);
        logic [7:0] e;
        check("ack_req_high", 32'(dma_req[l]), 32'd1);
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL sb_underrun: DMA offered 0x%0h with nothing expected", dma_data[l]);
        end else begin
            e = sb.pop_front();
            check("dma_data", 32'(dma_data[l]), 32'(e));
        end
        dma_ack[l] = 1'b1;
        dma_tc[l]  = tc_v;
        tick();
        dma_ack[l] = 1'b0;
        dma_tc[l]  = 1'b0;
    endtask

    task automatic wait_req(input int l, input int budget);
        int n = 0;
        while (!dma_req[l] && n < budget) begin
            tick();
            n++;
        end
        check("req_timeout", 32'(dma_req[l]), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{8'hA5, 16'd1};
        vecs[1] = '{8'h00, 16'd2};
        vecs[2] = '{8'hFF, 16'd3};
        vecs[3] = '{8'h3C, 16'd4};

        rst = 1'b1; sclr = '0; enable = '0; dma_ack = '0; dma_tc = '0;
        push_v = '0; fclr = '1; underflow = '0;
        for (int l = 0; l < NL; l++) push_d[l] = '0;
        tick();
        tick();
        check("rst_req",   32'(dma_req),    32'd0);
        check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_err",   32'(ack_error),  32'd0);
        check("rst_data",  32'(dma_data[0]),   32'd0);
        check("rst_count", 32'(xfer_count[0]), 32'd0);
        rst = 1'b0; fclr = '0; enable = '1;
        tick();

        // single-byte transfers, threshold 1
        for (int i = 0; i < 4; i++) begin
            push(0, vecs[i].data);
            check("t1_rdreq",   32'(fifo_rdreq[0]), 32'd1);
            check("t1_req_pre", 32'(dma_req[0]),    32'd0);
            tick();
            check("t1_req",   32'(dma_req[0]),    32'd1);
            check("t1_empty", 32'(fifo_empty[0]), 32'd1);
            do_ack(0, 1'b0);
            check("t1_count",  32'(xfer_count[0]), 32'(vecs[i].exp_count));
            check("t1_req_lo", 32'(dma_req[0]),    32'd0);
        end

        // stray ack while idle, then sclr
        dma_ack[0] = 1'b1;
        tick();
        dma_ack[0] = 1'b0;
        check("t5_err",   32'(ack_error[0]),  32'd1);
        check("t5_count", 32'(xfer_count[0]), 32'd4);
        sclr[0] = 1'b1;
        tick();
        sclr[0] = 1'b0;
        check("t5_clr_err",   32'(ack_error[0]),  32'd0);
        check("t5_clr_count", 32'(xfer_count[0]), 32'd0);

        // terminal count on the third of five bytes
        sb.delete();
        for (int i = 0; i < 5; i++) push(0, 8'(8'h10 + i));
        do_ack(0, 1'b0);
        do_ack(0, 1'b0);
        do_ack(0, 1'b1);
        check("t4_done",  32'(done[0]),       32'd1);
        check("t4_req",   32'(dma_req[0]),    32'd0);
        check("t4_count", 32'(xfer_count[0]), 32'd3);
        check("t4_usedw", 32'(fifo_usedw[0]), 32'd2);
        tick();
        check("t4_no_pop", 32'(fifo_usedw[0]), 32'd2);
        dma_ack[0] = 1'b1;
        tick();
        dma_ack[0] = 1'b0;
        check("t4_done_err",   32'(ack_error[0]),  32'd1);
        check("t4_done_count", 32'(xfer_count[0]), 32'd3);
        check("t4_still_done", 32'(done[0]),       32'd1);
        sclr[0] = 1'b1; fclr[0] = 1'b1;
        tick();
        sclr[0] = 1'b0; fclr[0] = 1'b0;
        check("t4_clr_done", 32'(done[0]), 32'd0);
        sb.delete();

        // threshold 16 with a full FIFO (usedw wrapped to 0), ack every cycle
        for (int i = 0; i < 16; i++) begin
            push(2, 8'(i));
            if (i == 14) check("t2_below_thr", 32'(fifo_rdreq[2]), 32'd0);
        end
        check("t2_rdreq", 32'(fifo_rdreq[2]), 32'd1);
        tick();
        for (int i = 0; i < 16; i++) do_ack(2, 1'b0);
        check("t2_count", 32'(xfer_count[2]), 32'd16);
        check("t2_req_lo", 32'(dma_req[2]),   32'd0);
        check("t2_empty", 32'(fifo_empty[2]), 32'd1);
        check("t2_sb_drained", 32'(sb.size()), 32'd0);

        // threshold 4: three bytes are not enough, the fourth starts the burst
        for (int i = 0; i < 3; i++) push(1, 8'(8'hC0 + i));
        repeat (3) tick();
        check("t3_req_hold", 32'(dma_req[1]),    32'd0);
        check("t3_no_pop",   32'(fifo_rdreq[1]), 32'd0);
        push(1, 8'hC3);
        check("t3_rdreq", 32'(fifo_rdreq[1]), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) do_ack(1, 1'b0);
        check("t3_count", 32'(xfer_count[1]), 32'd4);

        // async reset in the middle of a burst
        sb.delete();
        push(0, 8'h5A);
        push(0, 8'h6B);
        wait_req(0, 10);
        do_ack(0, 1'b0);
        check("t6_refilled", 32'(dma_req[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_req",   32'(dma_req),         32'd0);
        check("t6_rst_data",  32'(dma_data[0]),     32'd0);
        check("t6_rst_count", 32'(xfer_count[0]),   32'd0);
        check("t6_rst_rdreq", 32'(fifo_rdreq),      32'd0);
        tick();
        rst = 1'b0;
        sb.delete();

        // sclr coincident with ack: not counted, no pop that cycle
        push(0, 8'h77);
        push(0, 8'h88);
        wait_req(0, 10);
        dma_ack[0] = 1'b1;
        sclr[0]    = 1'b1;
        #1;
        check("t6_sclr_rdreq", 32'(fifo_rdreq[0]), 32'd0);
        tick();
        dma_ack[0] = 1'b0;
        sclr[0]    = 1'b0;
        check("t6_sclr_count", 32'(xfer_count[0]), 32'd0);
        check("t6_sclr_req",   32'(dma_req[0]),    32'd0);
        check("t6_sclr_data",  32'(dma_data[0]),   32'd0);
        check("t6_sclr_err",   32'(ack_error[0]),  32'd0);

        check("no_pop_on_empty", 32'(underflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fifo_dma_drain
